// File: rtl/demux_1_4_v.sv
// 1-to-4 registered demux of i_a by i_sel_code, with per-output saturating hit counters.
// Latency: one clock from input sample to o_code/o_sel_q/o_valid/o_hit_cnt.
// Backpressure: none; i_en=0 freezes every register, i_rst overrides i_en.
module demux_1_4_v #(
    parameter bit ACTIVE_LOW_OUT = 1'b0,
    parameter int CNT_W          = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_en,
    input  logic                 i_a,
    input  logic [1:0]           i_sel_code,
    output logic [3:0]           o_code,
    output logic                 o_valid,
    output logic [1:0]           o_sel_q,
    output logic [4*CNT_W-1:0]   o_hit_cnt
);

    // XOR mask applied at the register input so the reset value carries the polarity too.
    localparam logic [3:0]       POL_MASK = ACTIVE_LOW_OUT ? 4'hF : 4'h0;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [3:0]       route_onehot;
    logic [CNT_W-1:0] hit_cnt [4];

    always_comb begin
        route_onehot             = 4'b0000;
        route_onehot[i_sel_code] = i_a;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_code  <= POL_MASK;
            o_valid <= 1'b0;
            o_sel_q <= 2'b00;
        end else if (i_en) begin
            o_code  <= route_onehot ^ POL_MASK;
            o_valid <= 1'b1;
            o_sel_q <= i_sel_code;
        end
    end

    for (genvar k = 0; k < 4; k++) begin : g_hit
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                hit_cnt[k] <= '0;
            end else if (i_en && i_a && (i_sel_code == 2'(k)) && (hit_cnt[k] != CNT_MAX)) begin
                hit_cnt[k] <= hit_cnt[k] + CNT_W'(1);
            end
        end
        assign o_hit_cnt[k*CNT_W +: CNT_W] = hit_cnt[k];
    end

endmodule

// File: tb/tb_demux_1_4_v.sv
// Bench for demux_1_4_v: default, active-low and 2-bit-counter instances share one stimulus stream.
// A queue-free behavioural model predicts every output; literal checks pin the model.
module tb_demux_1_4_v;

    logic       clk = 1'b0;
    logic       rst, en, a;
    logic [1:0] sel;

    logic [3:0]  code_d, code_l, code_s;
    logic        vld_d, vld_l, vld_s;
    logic [1:0]  selq_d, selq_l, selq_s;
    logic [31:0] hit_d, hit_l;
    logic [7:0]  hit_s;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    demux_1_4_v u_dut_d (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_a(a), .i_sel_code(sel),
        .o_code(code_d), .o_valid(vld_d), .o_sel_q(selq_d), .o_hit_cnt(hit_d)
    );

    demux_1_4_v #(.ACTIVE_LOW_OUT(1'b1)) u_dut_l (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_a(a), .i_sel_code(sel),
        .o_code(code_l), .o_valid(vld_l), .o_sel_q(selq_l), .o_hit_cnt(hit_l)
    );

    demux_1_4_v #(.CNT_W(2)) u_dut_s (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_a(a), .i_sel_code(sel),
        .o_code(code_s), .o_valid(vld_s), .o_sel_q(selq_s), .o_hit_cnt(hit_s)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: logical one-hot = i_a << sel; counters count hits per select, clamped at cap.
    bit         m_known = 1'b0;
    logic [3:0] m_log [3];
    bit         m_vld [3];
    logic [1:0] m_sel [3];
    int         m_cnt [3][4];

    function automatic int cap(input int i);
        return (i == 2) ? 3 : 255;
    endfunction

    always @(posedge clk) begin
        if (rst === 1'b1) m_known <= 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                m_log[i] <= 4'h0;
                m_vld[i] <= 1'b0;
                m_sel[i] <= 2'd0;
                for (int k = 0; k < 4; k++) m_cnt[i][k] <= 0;
            end else if (en) begin
                m_log[i] <= a ? (4'd1 << sel) : 4'd0;
                m_vld[i] <= 1'b1;
                m_sel[i] <= sel;
                if (a) m_cnt[i][int'(sel)] <= (m_cnt[i][int'(sel)] + 1 > cap(i)) ? cap(i)
                                                                              : m_cnt[i][int'(sel)] + 1;
            end
        end
    end

    // Outputs are compared on the falling edge, half a cycle away from updates.
    always @(negedge clk) begin
        if (m_known) begin
            for (int i = 0; i < 3; i++) begin
                logic [3:0] c;
                logic       v;
                logic [1:0] s;
                int         h;
                c = (i == 0) ? code_d : (i == 1) ? code_l : code_s;
                v = (i == 0) ? vld_d  : (i == 1) ? vld_l  : vld_s;
                s = (i == 0) ? selq_d : (i == 1) ? selq_l : selq_s;
                chk($sformatf("inst%0d o_code", i), 32'(c), 32'(m_log[i] ^ ((i == 1) ? 4'hF : 4'h0)));
                chk($sformatf("inst%0d o_valid", i), 32'(v), 32'(m_vld[i]));
                chk($sformatf("inst%0d o_sel_q", i), 32'(s), 32'(m_sel[i]));
                for (int k = 0; k < 4; k++) begin
                    h = (i == 0) ? int'(hit_d[k*8 +: 8]) :
                        (i == 1) ? int'(hit_l[k*8 +: 8]) : int'(hit_s[k*2 +: 2]);
                    chk($sformatf("inst%0d hit%0d", i, k), 32'(h), 32'(m_cnt[i][k]));
                end
            end
        end
    end

    task automatic cyc(input logic r, input logic e, input logic d, input logic [1:0] s);
        @(negedge clk);
        rst = r; en = e; a = d; sel = s;
        @(posedge clk);
        #1;
    endtask

    logic [3:0] exp_walk [4];

    initial begin
        exp_walk[0] = 4'b0001; exp_walk[1] = 4'b0010;
        exp_walk[2] = 4'b0100; exp_walk[3] = 4'b1000;
        rst = 1'b1; en = 1'b0; a = 1'b0; sel = 2'd0;

        cyc(1, 0, 0, 0);
        cyc(1, 1, 1, 3);
        chk("reset code", 32'(code_d), 32'h0);
        chk("reset code active-low", 32'(code_l), 32'hF);
        chk("reset valid", 32'(vld_d), 32'h0);
        chk("reset hits", hit_d, 32'h0);

        // No capture while i_en is low, even with reset released.
        cyc(0, 0, 1, 1);
        chk("no capture valid", 32'(vld_d), 32'h0);

        for (int k = 0; k < 4; k++) begin
            cyc(0, 1, 1, 2'(k));
            chk($sformatf("walk%0d code", k), 32'(code_d), 32'(exp_walk[k]));
            chk($sformatf("walk%0d sel_q", k), 32'(selq_d), 32'(k));
            if (k == 1) chk("active-low sel1", 32'(code_l), 32'hD);
        end
        chk("walk valid", 32'(vld_d), 32'h1);

        for (int v = 0; v < 8; v++) begin
            logic [2:0] vv;
            vv = 3'(v);
            cyc(0, 1, vv[2], vv[1:0]);
            if (!vv[2]) chk($sformatf("sweep a=0 sel%0d code", v), 32'(code_d), 32'h0);
        end
        chk("sweep hits", hit_d, 32'h02020202);

        cyc(1, 0, 0, 0);
        cyc(0, 1, 1, 2);
        for (int j = 0; j < 3; j++) cyc(0, 0, 1'(j), 2'(j));
        chk("hold code", 32'(code_d), 32'h4);
        chk("hold hit2", 32'(hit_d[23:16]), 32'h1);

        cyc(1, 1, 1, 3);
        chk("rst-prio code", 32'(code_d), 32'h0);
        chk("rst-prio valid", 32'(vld_d), 32'h0);
        chk("rst-prio hits", hit_d, 32'h0);

        for (int j = 0; j < 5; j++) cyc(0, 1, 1, 3);
        chk("sat hits", 32'(hit_s), 32'hC0 >> 6 << 6);
        chk("nosat hit3", 32'(hit_d[31:24]), 32'h5);

        cyc(0, 0, 0, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
